md_sequencer: RTL and testbench

Multi-cycle controller for the combinational multiply/divide unit (MDC) in the P6 pipeline's EX stage. It latches operands and the operation on a start request, holds them stable at the MDC inputs, and asserts Busy for a fixed latency. When the latency expires it commits MDCResult_hi/lo into the architectural HI/LO registers. It also services mthi/mtlo writes and supplies HI/LO for mfhi/mflo; the hazard unit stalls on Busy.

---
 rtl/md_sequencer_pkg.sv | 27 ++
 rtl/md_sequencer_if.sv | 34 +++
 rtl/md_latency_counter.sv | 28 ++
 rtl/md_sequencer.sv | 93 +++++++++
 tb/tb_md_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// MDC op encodings, sequencer states and the latency counter width.
package md_sequencer_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;

    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Codes 5-7 are reserved and must never start an operation
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// EX-stage <-> sequencer bundle: instruction request, HI/LO access and the
// operand/result path to the external combinational MDC.
interface md_sequencer_if;

    logic        Start;
    logic [2:0]  MDCCtrl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        HiLoWe;
    logic        HiLoSel;
    logic [31:0] HiLoWD;
    logic [31:0] MDCResult_hi;
    logic [31:0] MDCResult_lo;
    logic [31:0] Md_SrcA;
    logic [31:0] Md_SrcB;
    logic [2:0]  Md_Ctrl;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] HiLoRD;

    modport slave (
        input  Start, MDCCtrl, SrcA, SrcB, HiLoWe, HiLoSel, HiLoWD,
        input  MDCResult_hi, MDCResult_lo,
        output Md_SrcA, Md_SrcB, Md_Ctrl, Busy, HI, LO, HiLoRD
    );

    modport master (
        output Start, MDCCtrl, SrcA, SrcB, HiLoWe, HiLoSel, HiLoWD,
        output MDCResult_hi, MDCResult_lo,
        input  Md_SrcA, Md_SrcB, Md_Ctrl, Busy, HI, LO, HiLoRD
    );

endinterface

// File: rtl/md_latency_counter.sv
// Down-counter timing a multiply/divide: loaded with the op latency,
// decrements to zero and flags the final busy cycle.
module md_latency_counter
    import md_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             last
);

    logic [CNT_W-1:0] count;

    // Parks at zero while idle so no spurious last flag can appear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle controller for the combinational MDC: holds operands stable
// for a fixed latency, then commits the result into HI/LO.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  bus
);

    state_e           state;
    logic             busy;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      md_src_a;
    logic [31:0]      md_src_b;
    logic [2:0]       md_ctrl;
    logic             start_ok;
    logic             count_last;
    logic             div_by_zero;
    logic [CNT_W-1:0] load_value;

    assign start_ok    = (state == ST_IDLE) && bus.Start && is_valid_op(bus.MDCCtrl);
    assign load_value  = is_div_op(bus.MDCCtrl) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    assign div_by_zero = is_div_op(md_ctrl) && (md_src_b == '0);

    md_latency_counter u_latency (
        .clk        (clk),
        .reset      (reset),
        .load       (start_ok),
        .load_value (load_value),
        .last       (count_last)
    );

    // A valid start takes priority over an mthi/mtlo in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            md_src_a <= '0;
            md_src_b <= '0;
            md_ctrl  <= MD_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        md_src_a <= bus.SrcA;
                        md_src_b <= bus.SrcB;
                        md_ctrl  <= bus.MDCCtrl;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end else if (bus.HiLoWe) begin
                        if (bus.HiLoSel) begin
                            hi <= bus.HiLoWD;
                        end else begin
                            lo <= bus.HiLoWD;
                        end
                    end
                end
                ST_RUN: begin
                    if (count_last) begin
                        if (!div_by_zero) begin
                            hi <= bus.MDCResult_hi;
                            lo <= bus.MDCResult_lo;
                        end
                        md_ctrl <= MD_NONE;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Md_SrcA = md_src_a;
    assign bus.Md_SrcB = md_src_b;
    assign bus.Md_Ctrl = md_ctrl;
    assign bus.Busy    = busy;
    assign bus.HI      = hi;
    assign bus.LO      = lo;
    assign bus.HiLoRD  = bus.HiLoSel ? hi : lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a behavioural MDC driving the
// result inputs from the latched Md_* operands.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    logic clk;
    logic reset;
    int   passCount;
    int   checkCount;
    int   bc;

    md_sequencer_if bus ();

    md_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the MDC; a divide by zero yields a marker that must never reach HI/LO
    always_comb begin
        logic [63:0] prod;
        prod = '0;
        bus.MDCResult_hi = '0;
        bus.MDCResult_lo = '0;
        case (bus.Md_Ctrl)
            MD_MULT: begin
                prod = $signed({{32{bus.Md_SrcA[31]}}, bus.Md_SrcA}) *
                       $signed({{32{bus.Md_SrcB[31]}}, bus.Md_SrcB});
                bus.MDCResult_hi = prod[63:32];
                bus.MDCResult_lo = prod[31:0];
            end
            MD_MULTU: begin
                prod = {32'd0, bus.Md_SrcA} * {32'd0, bus.Md_SrcB};
                bus.MDCResult_hi = prod[63:32];
                bus.MDCResult_lo = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (bus.Md_SrcB == '0) begin
                    bus.MDCResult_hi = 32'hDEADBEEF;
                    bus.MDCResult_lo = 32'hDEADBEEF;
                end else if (bus.Md_Ctrl == MD_DIV) begin
                    bus.MDCResult_lo = $signed(bus.Md_SrcA) / $signed(bus.Md_SrcB);
                    bus.MDCResult_hi = $signed(bus.Md_SrcA) % $signed(bus.Md_SrcB);
                end else begin
                    bus.MDCResult_lo = bus.Md_SrcA / bus.Md_SrcB;
                    bus.MDCResult_hi = bus.Md_SrcA % bus.Md_SrcB;
                end
            end
            default: begin
                bus.MDCResult_hi = '0;
                bus.MDCResult_lo = '0;
            end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) begin
            passCount = passCount + 1;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of request inputs, then drops the one-shot strobes
    task automatic applyStimulus(input logic start, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic we, input logic sel,
                                 input logic [31:0] wd);
        bus.Start   = start;
        bus.MDCCtrl = op;
        bus.SrcA    = a;
        bus.SrcB    = b;
        bus.HiLoWe  = we;
        bus.HiLoSel = sel;
        bus.HiLoWD  = wd;
        @(posedge clk);
        #1;
        bus.Start   = 1'b0;
        bus.MDCCtrl = MD_NONE;
        bus.HiLoWe  = 1'b0;
        bc          = 0;
    endtask

    task automatic tick();
        if (bus.Busy) bc = bc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        for (int guard = 0; guard < 40 && bus.Busy; guard++) tick();
    endtask

    initial begin
        passCount   = 0;
        checkCount  = 0;
        bc          = 0;
        reset       = 1'b1;
        bus.Start   = 1'b0;
        bus.MDCCtrl = MD_NONE;
        bus.SrcA    = '0;
        bus.SrcB    = '0;
        bus.HiLoWe  = 1'b0;
        bus.HiLoSel = 1'b0;
        bus.HiLoWD  = '0;
        #12;
        checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
        checkOutput("reset_hi", bus.HI, 32'd0);
        checkOutput("reset_lo", bus.LO, 32'd0);
        checkOutput("reset_ctrl", 32'(bus.Md_Ctrl), 32'd0);
        checkOutput("reset_srca", bus.Md_SrcA, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // signed multiply
        applyStimulus(1'b1, MD_MULT, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0, '0);
        checkOutput("mult_ctrl", 32'(bus.Md_Ctrl), 32'd1);
        waitIdle();
        checkOutput("mult_busy_cycles", 32'(bc), 32'd5);
        checkOutput("mult_hi", bus.HI, 32'hFFFFFFFF);
        checkOutput("mult_lo", bus.LO, 32'hFFFFFFFA);
        checkOutput("mult_ctrl_cleared", 32'(bus.Md_Ctrl), 32'd0);

        // unsigned multiply, operand changes during RUN must not leak in
        applyStimulus(1'b1, MD_MULTU, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0, '0);
        bus.SrcA = 32'd0;
        tick();
        checkOutput("multu_srca_held", bus.Md_SrcA, 32'hFFFFFFFE);
        waitIdle();
        checkOutput("multu_busy_cycles", 32'(bc), 32'd5);
        checkOutput("multu_hi", bus.HI, 32'h00000002);
        checkOutput("multu_lo", bus.LO, 32'hFFFFFFFA);

        // signed divide -7 / 2
        applyStimulus(1'b1, MD_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, '0);
        waitIdle();
        checkOutput("div_busy_cycles", 32'(bc), 32'd10);
        checkOutput("div_lo", bus.LO, 32'hFFFFFFFD);
        checkOutput("div_hi", bus.HI, 32'hFFFFFFFF);

        // unsigned divide 7 / 2 with an ignored Start arriving mid-run
        applyStimulus(1'b1, MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0, '0);
        bus.Start   = 1'b1;
        bus.MDCCtrl = MD_MULT;
        bus.SrcB    = 32'd0;
        tick();
        bus.Start   = 1'b0;
        bus.MDCCtrl = MD_NONE;
        checkOutput("divu_ctrl_held", 32'(bus.Md_Ctrl), 32'd4);
        checkOutput("divu_srcb_held", bus.Md_SrcB, 32'd2);
        waitIdle();
        checkOutput("divu_busy_cycles", 32'(bc), 32'd10);
        checkOutput("divu_lo", bus.LO, 32'd3);
        checkOutput("divu_hi", bus.HI, 32'd1);

        // mthi / mtlo and read-back through HiLoRD
        applyStimulus(1'b0, MD_NONE, '0, '0, 1'b1, 1'b1, 32'h12345678);
        applyStimulus(1'b0, MD_NONE, '0, '0, 1'b1, 1'b0, 32'h9ABCDEF0);
        bus.HiLoSel = 1'b1;
        #1;
        checkOutput("rd_hi", bus.HiLoRD, 32'h12345678);
        bus.HiLoSel = 1'b0;
        #1;
        checkOutput("rd_lo", bus.HiLoRD, 32'h9ABCDEF0);

        // mtlo during RUN is ignored
        applyStimulus(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0, '0);
        bus.HiLoWe  = 1'b1;
        bus.HiLoSel = 1'b0;
        bus.HiLoWD  = 32'hDEADBEEF;
        tick();
        bus.HiLoWe = 1'b0;
        checkOutput("run_write_ignored", bus.LO, 32'h9ABCDEF0);
        waitIdle();
        checkOutput("mult23_lo", bus.LO, 32'd6);
        checkOutput("mult23_hi", bus.HI, 32'd0);

        // Start and mthi in the same cycle: write dropped
        applyStimulus(1'b1, MD_MULT, 32'd1, 32'd1, 1'b1, 1'b1, 32'hAAAAAAAA);
        checkOutput("start_we_busy", 32'(bus.Busy), 32'd1);
        checkOutput("start_we_hi", bus.HI, 32'd0);
        waitIdle();
        checkOutput("mult11_lo", bus.LO, 32'd1);

        // divide by zero leaves HI/LO untouched after full latency
        applyStimulus(1'b0, MD_NONE, '0, '0, 1'b1, 1'b1, 32'h00000077);
        applyStimulus(1'b0, MD_NONE, '0, '0, 1'b1, 1'b0, 32'h00000055);
        applyStimulus(1'b1, MD_DIV, 32'd9, 32'd0, 1'b0, 1'b0, '0);
        waitIdle();
        checkOutput("div0_busy_cycles", 32'(bc), 32'd10);
        checkOutput("div0_hi", bus.HI, 32'h00000077);
        checkOutput("div0_lo", bus.LO, 32'h00000055);

        // reserved op code never starts
        applyStimulus(1'b1, 3'd6, 32'd4, 32'd4, 1'b0, 1'b0, '0);
        checkOutput("op6_busy", 32'(bus.Busy), 32'd0);
        checkOutput("op6_ctrl", 32'(bus.Md_Ctrl), 32'd0);

        // asynchronous reset in the third busy cycle
        applyStimulus(1'b1, MD_MULT, 32'd5, 32'd7, 1'b0, 1'b0, '0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(bus.Busy), 32'd0);
        checkOutput("arst_hi", bus.HI, 32'd0);
        checkOutput("arst_lo", bus.LO, 32'd0);
        checkOutput("arst_srca", bus.Md_SrcA, 32'd0);
        checkOutput("arst_srcb", bus.Md_SrcB, 32'd0);
        checkOutput("arst_ctrl", 32'(bus.Md_Ctrl), 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, MD_MULTU, 32'd2, 32'd3, 1'b0, 1'b0, '0);
        waitIdle();
        checkOutput("post_rst_busy_cycles", 32'(bc), 32'd5);
        checkOutput("post_rst_lo", bus.LO, 32'd6);
        checkOutput("post_rst_hi", bus.HI, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
